// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between an instruction-fetch
// requester (i_*) and a data requester (d_*). Each access takes an ACC cycle
// (address/grant) and an RSP cycle (read data / write ack), giving one access
// every two cycles when requests are back-to-back.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   i_req, i_addr              fetch request (always a word read)
//   i_gnt, i_rvalid, i_rdata   fetch accept pulse, data-valid pulse, data
//   d_req, d_we, d_funct3,
//   d_addr, d_wdata            data request
//   d_gnt, d_rvalid, d_rdata   data accept pulse, data/ack pulse, data
//   mem_wren, mem_funct3,
//   mem_address, mem_data_in   memory command, zero/word-default outside ACC
//   mem_data_out               memory read data, valid one cycle after address
//   busy                       high whenever the FSM is not IDLE
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on conflict;
// the default build gives the data requester fixed priority.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_funct3,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_wren,
   output logic [2:0]        mem_funct3,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ACC_I = 3'd1;
   localparam logic [2:0] ACC_D = 3'd2;
   localparam logic [2:0] RSP_I = 3'd3;
   localparam logic [2:0] RSP_D = 3'd4;

   localparam logic [2:0] F3_WORD = 3'b010;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic              arb_pt;
   logic              pick_i;
   logic              pick_d;
   logic              lat_we;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

`ifdef MEM_ARB_RR_EN
   logic              last_d;   // 1 when the data side won the last grant
`endif

   // Arbitration and next-state decode; grants only happen at IDLE/RSP.
   always_comb begin
      state_nxt = state;
      pick_i    = 1'b0;
      pick_d    = 1'b0;
      arb_pt    = (state == IDLE) || (state == RSP_I) || (state == RSP_D);

      if (arb_pt) begin
         if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            pick_i = last_d;
            pick_d = !last_d;
`else
            pick_d = 1'b1;
`endif
         end else begin
            pick_i = i_req;
            pick_d = d_req;
         end
      end

      case (state)
         IDLE, RSP_I, RSP_D: begin
            if (pick_d)      state_nxt = ACC_D;
            else if (pick_i) state_nxt = ACC_I;
            else             state_nxt = IDLE;
         end
         ACC_I:   state_nxt = RSP_I;
         ACC_D:   state_nxt = RSP_D;
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs; the memory command registers double as
   // the latched request fields, so they are only non-default during ACC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         i_gnt       <= 1'b0;
         d_gnt       <= 1'b0;
         i_rvalid    <= 1'b0;
         d_rvalid    <= 1'b0;
         mem_wren    <= 1'b0;
         mem_funct3  <= F3_WORD;
         mem_address <= '0;
         mem_data_in <= '0;
         lat_we      <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
         last_d      <= 1'b1;
`endif
      end else begin
         state    <= state_nxt;
         busy     <= (state_nxt != IDLE);
         i_gnt    <= pick_i;
         d_gnt    <= pick_d;
         i_rvalid <= (state == ACC_I);
         d_rvalid <= (state == ACC_D);
         mem_wren <= pick_d && d_we;

         if (pick_d) begin
            mem_address <= d_addr;
            mem_data_in <= d_wdata;
            mem_funct3  <= d_funct3;
            lat_we      <= d_we;
         end else if (pick_i) begin
            mem_address <= i_addr;
            mem_data_in <= '0;
            mem_funct3  <= F3_WORD;
         end else begin
            mem_address <= '0;
            mem_data_in <= '0;
            mem_funct3  <= F3_WORD;
         end

         if (state == RSP_I) i_rdata_q <= mem_data_out;
         if (state == RSP_D) d_rdata_q <= lat_we ? '0 : mem_data_out;

`ifdef MEM_ARB_RR_EN
         if (pick_d)      last_d <= 1'b1;
         else if (pick_i) last_d <= 1'b0;
`endif
      end
   end

   // Memory data only arrives in the RSP cycle, so rdata passes it through
   // alongside rvalid and then holds it until the next response.
   assign i_rdata = (state == RSP_I) ? mem_data_out : i_rdata_q;
   assign d_rdata = (state == RSP_D) ? (lat_we ? '0 : mem_data_out) : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected grant and
// response entries; a negedge monitor pops and compares them as the DUT
// presents gnt/rvalid, and checks idle memory defaults and exclusivity.
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [2:0]  d_funct3;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_wren;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;
   logic        busy;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr),
      .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_wren(mem_wren), .mem_funct3(mem_funct3),
      .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .busy(busy)
   );

   typedef struct {
      logic        d;
      logic [31:0] addr;
      logic [2:0]  f3;
      logic        we;
      logic [31:0] wd;
   } gnt_t;

   typedef struct {
      logic        d;
      logic [31:0] rd;
   } rsp_t;

   gnt_t gq[$];
   rsp_t rq[$];
   int   total = 0;
   int   bad   = 0;

   logic [31:0] mem [logic [31:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Synchronous memory: data for the ACC address appears in the RSP cycle.
   always @(posedge clk) begin
      if (mem_wren) mem[mem_address] = mem_data_in;
      mem_data_out <= mem.exists(mem_address) ? mem[mem_address] : 32'h0;
   end

   // Monitor
   logic pgi, pgd;
   gnt_t g;
   rsp_t r;
   always @(negedge clk) begin
      if (!reset) begin
         pgi = 1'b0;
         pgd = 1'b0;
      end else begin
         chk("gnt_excl", 32'(i_gnt & d_gnt), 32'd0);
         chk("rv_excl", 32'(i_rvalid & d_rvalid), 32'd0);
         chk("i_rv_follow", 32'(i_rvalid), 32'(pgi));
         chk("d_rv_follow", 32'(d_rvalid), 32'(pgd));
         if (i_gnt || d_gnt) begin
            if (gq.size() == 0) chk("gnt_unexpected", 32'd1, 32'd0);
            else begin
               g = gq.pop_front();
               chk("gnt_who", 32'(d_gnt), 32'(g.d));
               chk("gnt_addr", mem_address, g.addr);
               chk("gnt_f3", 32'(mem_funct3), 32'(g.f3));
               chk("gnt_wren", 32'(mem_wren), 32'(g.we));
               chk("gnt_wdata", mem_data_in, g.wd);
               chk("gnt_busy", 32'(busy), 32'd1);
            end
         end else begin
            chk("idle_wren", 32'(mem_wren), 32'd0);
            chk("idle_addr", mem_address, 32'd0);
            chk("idle_din", mem_data_in, 32'd0);
            chk("idle_f3", 32'(mem_funct3), 32'd2);
         end
         if (i_rvalid || d_rvalid) begin
            if (rq.size() == 0) chk("rv_unexpected", 32'd1, 32'd0);
            else begin
               r = rq.pop_front();
               chk("rv_who", 32'(d_rvalid), 32'(r.d));
               chk("rv_rdata", d_rvalid ? d_rdata : i_rdata, r.rd);
               chk("rv_busy", 32'(busy), 32'd1);
            end
         end
         pgi = i_gnt;
         pgd = d_gnt;
      end
   end

   task automatic push_exp(input logic d, input logic [31:0] a, input logic [2:0] f3,
                           input logic we, input logic [31:0] wd, input logic [31:0] rd);
      gnt_t ge;
      rsp_t re;
      ge.d = d; ge.addr = a; ge.f3 = f3; ge.we = we; ge.wd = wd;
      re.d = d; re.rd = rd;
      gq.push_back(ge);
      rq.push_back(re);
   endtask

   // Raise a request and hold it until its grant; returns cycles to grant.
   task automatic issue_i(input logic [31:0] a, input logic [31:0] rd, output int lat);
      push_exp(1'b0, a, 3'b010, 1'b0, 32'h0, rd);
      i_req = 1'b1; i_addr = a;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!i_gnt && lat < 20);
      if (!i_gnt) chk("i_gnt_timeout", 32'd0, 32'd1);
      i_req = 1'b0; i_addr = 32'h0;
   endtask

   task automatic issue_d(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, output int lat);
      push_exp(1'b1, a, f3, we, wd, rd);
      d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!d_gnt && lat < 20);
      if (!d_gnt) chk("d_gnt_timeout", 32'd0, 32'd1);
      d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h0; d_wdata = 32'h0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (busy && n < 20);
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      int lat;
      mem[32'h0000_1000] = 32'h0050_0093;
      mem[32'h0000_0020] = 32'h1111_2222;
      mem[32'h0000_0008] = 32'hCAFE_F00D;
      reset = 1'b0;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h0; d_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gnt", 32'({i_gnt, d_gnt}), 32'd0);
      chk("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
      chk("rst_wren", 32'(mem_wren), 32'd0);
      chk("rst_f3", 32'(mem_funct3), 32'd2);
      chk("rst_addr", mem_address, 32'd0);
      chk("rst_din", mem_data_in, 32'd0);
      chk("rst_irdata", i_rdata, 32'd0);
      chk("rst_drdata", d_rdata, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Single fetch: grant one cycle after request is seen, then data
      issue_i(32'h0000_1000, 32'h0050_0093, lat);
      chk("i_lat", 32'(lat), 32'd1);
      wait_idle();

      // Write then read-back, then a byte-size read
      issue_d(1'b1, 3'b010, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0, lat);
      chk("d_wr_lat", 32'(lat), 32'd1);
      wait_idle();
      issue_d(1'b0, 3'b010, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, lat);
      wait_idle();
      issue_d(1'b0, 3'b100, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, lat);
      wait_idle();
      chk("i_rdata_hold", i_rdata, 32'h0050_0093);
      chk("d_rdata_hold", d_rdata, 32'hCAFE_F00D);

      // Back-to-back: fetch raised during RSP_D is granted right after it
      issue_d(1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h1111_2222, lat);
      @(posedge clk); #1;
      chk("b2b_in_rsp_d", 32'(d_rvalid), 32'd1);
      push_exp(1'b0, 32'h0000_1000, 3'b010, 1'b0, 32'h0, 32'h0050_0093);
      i_req = 1'b1; i_addr = 32'h0000_1000;
      @(posedge clk); #1;
      chk("b2b_i_gnt", 32'(i_gnt), 32'd1);
      chk("b2b_busy", 32'(busy), 32'd1);
      i_req = 1'b0; i_addr = 32'h0;
      wait_idle();

      // Reset during ACC_D write: aborted, no ack
      issue_d(1'b1, 3'b010, 32'h0000_0030, 32'h1234_5678, 32'h0, lat);
      chk("abort_wren_pre", 32'(mem_wren), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("abort_wren", 32'(mem_wren), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_gnt", 32'(d_gnt), 32'd0);
      gq.delete();
      rq.delete();
      @(posedge clk); #1;
      chk("abort_no_rvalid", 32'(d_rvalid), 32'd0);
      chk("abort_no_write", 32'(mem.exists(32'h0000_0030)), 32'd0);

      // Conflict: both requests held from reset release for six cycles
      i_req = 1'b1; i_addr = 32'h0000_1000;
      d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h0000_0020; d_wdata = 32'h0;
`ifdef MEM_ARB_RR_EN
      push_exp(1'b0, 32'h0000_1000, 3'b010, 1'b0, 32'h0, 32'h0050_0093);
      push_exp(1'b1, 32'h0000_0020, 3'b010, 1'b0, 32'h0, 32'h1111_2222);
      push_exp(1'b0, 32'h0000_1000, 3'b010, 1'b0, 32'h0, 32'h0050_0093);
`else
      push_exp(1'b1, 32'h0000_0020, 3'b010, 1'b0, 32'h0, 32'h1111_2222);
      push_exp(1'b1, 32'h0000_0020, 3'b010, 1'b0, 32'h0, 32'h1111_2222);
      push_exp(1'b1, 32'h0000_0020, 3'b010, 1'b0, 32'h0, 32'h1111_2222);
`endif
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("first_arb_gnt", 32'(i_gnt | d_gnt), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_addr = 32'h0;
      wait_idle();

      repeat (2) @(posedge clk);
      #1;
      chk("gq_empty", 32'(gq.size()), 32'd0);
      chk("rq_empty", 32'(rq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
